ni_output_scheduler: RTL and testbench

// - Packet-aware output arbiter for the sensor NI: shares the single 16-bit NI output port between the

---
 rtl/ni_pkg.sv | 15 +
 rtl/ni_starve_counter.sv | 32 +++
 rtl/ni_output_scheduler.sv | 104 ++++++++++
 tb/tb_ni_output_scheduler.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ni_pkg.sv
// Shared definitions for the sensor NI output path: flit geometry and
// the packet-lock state encoding used by the output scheduler.
package ni_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int HEAD_BIT   = DATA_WIDTH - 1;
    localparam int TAIL_BIT   = DATA_WIDTH - 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCK_PRI = 2'd1,
        LOCK_REG = 2'd2
    } state_t;

endpackage

// File: rtl/ni_starve_counter.sv
// Saturating count of priority packets granted while regular traffic waits;
// at_limit tells the scheduler to force the next boundary grant to regular.
module ni_starve_counter #(
    parameter int LIMIT     = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [CNT_WIDTH-1:0] LIMIT_V = CNT_WIDTH'(LIMIT);

    logic [CNT_WIDTH-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != LIMIT_V) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    assign at_limit = (cnt == LIMIT_V);

endmodule

// File: rtl/ni_output_scheduler.sv
// Packet-aware arbiter sharing the NI output port between the priority and
// regular FWFT FIFOs; a grant is held from head to tail flit.
module ni_output_scheduler #(
    parameter int DATA_WIDTH   = ni_pkg::DATA_WIDTH,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pri_empty,
    input  logic [DATA_WIDTH-1:0] pri_data,
    output logic                  pri_read,
    input  logic                  reg_empty,
    input  logic [DATA_WIDTH-1:0] reg_data,
    output logic                  reg_read,
    input  logic                  output_bussy,
    output logic                  output_req,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_sel,
    output logic                  err_hdr
);

    import ni_pkg::*;

    localparam int HEAD_IDX = DATA_WIDTH - 1;
    localparam int TAIL_IDX = DATA_WIDTH - 3;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > (2 ** CNT_WIDTH) - 1) begin : g_bad_limit
        $error("STARVE_LIMIT must fit in CNT_WIDTH bits");
    end

    state_t state;
    logic   at_limit;
    logic   xfer;
    logic   at_boundary;
    logic   flit_head;
    logic   flit_tail;

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned and infers a latch.
    always_comb begin
        output_sel = 1'b0;
        output_req = 1'b0;
        unique case (state)
            IDLE: begin
                if (!reg_empty && (pri_empty || at_limit)) begin
                    output_req = 1'b1;
                end else if (!pri_empty) begin
                    output_sel = 1'b1;
                    output_req = 1'b1;
                end
            end
            LOCK_PRI: begin
                output_sel = 1'b1;
                output_req = !pri_empty;
            end
            LOCK_REG: output_req = !reg_empty;
            default:  output_req = 1'b0;
        endcase
        // Nothing is offered while reset is held, so no flit can leave unpopped.
        if (rst) output_req = 1'b0;
    end

    assign output_data = output_sel ? pri_data : reg_data;
    assign xfer        = output_req && !output_bussy;
    assign pri_read    = xfer && output_sel;
    assign reg_read    = xfer && !output_sel;
    assign at_boundary = (state == IDLE);
    assign flit_head   = output_data[HEAD_IDX];
    assign flit_tail   = output_data[TAIL_IDX];

    ni_starve_counter #(
        .LIMIT    (STARVE_LIMIT),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .inc     (xfer && at_boundary && output_sel && !reg_empty),
        .clr     (xfer && at_boundary && !output_sel),
        .at_limit(at_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            err_hdr <= 1'b0;
        end else begin
            err_hdr <= xfer && at_boundary && !flit_head;
            unique case (state)
                IDLE: begin
                    // A headless boundary flit is sent as a lone packet, never locking.
                    if (xfer && flit_head && !flit_tail) begin
                        state <= output_sel ? LOCK_PRI : LOCK_REG;
                    end
                end
                LOCK_PRI, LOCK_REG: begin
                    if (xfer && flit_tail) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ni_output_scheduler.sv
// Directed bench for ni_output_scheduler: a vector table walked cycle by
// cycle plus hand sequences for starvation and reset mid-packet.
module tb_ni_output_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        pri_empty;
    logic [15:0] pri_data;
    logic        pri_read;
    logic        reg_empty;
    logic [15:0] reg_data;
    logic        reg_read;
    logic        output_bussy;
    logic        output_req;
    logic [15:0] output_data;
    logic        output_sel;
    logic        err_hdr;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        pe;
        logic [15:0] pd;
        logic        re;
        logic [15:0] rd;
        logic        bz;
        logic        req;
        logic        sel;
        logic [15:0] data;
        logic        prd;
        logic        rrd;
        logic        err;
    } vec_t;

    localparam int NVEC = 25;
    vec_t tbl [NVEC];

    ni_output_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .pri_empty   (pri_empty),
        .pri_data    (pri_data),
        .pri_read    (pri_read),
        .reg_empty   (reg_empty),
        .reg_data    (reg_data),
        .reg_read    (reg_read),
        .output_bussy(output_bussy),
        .output_req  (output_req),
        .output_data (output_data),
        .output_sel  (output_sel),
        .err_hdr     (err_hdr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge and sample the settled outputs 1ns later.
    task automatic apply_and_check(input vec_t v, input string tag);
        @(negedge clk);
        rst          = 1'b0;
        pri_empty    = v.pe;
        pri_data     = v.pd;
        reg_empty    = v.re;
        reg_data     = v.rd;
        output_bussy = v.bz;
        #1;
        check({tag, " req"}, 16'(output_req), 16'(v.req));
        check({tag, " sel"}, 16'(output_sel), 16'(v.sel));
        check({tag, " pri_read"}, 16'(pri_read), 16'(v.prd));
        check({tag, " reg_read"}, 16'(reg_read), 16'(v.rrd));
        check({tag, " err_hdr"}, 16'(err_hdr), 16'(v.err));
        if (v.req) check({tag, " data"}, output_data, v.data);
    endtask

    function automatic vec_t both_single(input logic exp_pri);
        // pe, pd, re, rd, bz, req, sel, data, prd, rrd, err
        return '{1'b0, 16'hA000, 1'b0, 16'hA0FF, 1'b0, 1'b1, exp_pri,
                 exp_pri ? 16'hA000 : 16'hA0FF, exp_pri, !exp_pri, 1'b0};
    endfunction

    initial begin
        // pe, pd, re, rd, bz | req, sel, data, prd, rrd, err
        // Priority-only 3-flit packet.
        tbl[0]  = '{1'b0, 16'h8001, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h8001, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 16'h0002, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 16'h2003, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h2003, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        // Locked priority source empties after head; regular must not steal the port.
        tbl[4]  = '{1'b0, 16'h8001, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h8001, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 16'h8001, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 16'h8001, 1'b0, 16'hA000, 1'b0, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 16'h2005, 1'b0, 16'hA000, 1'b0, 1'b1, 1'b1, 16'h2005, 1'b1, 1'b0, 1'b0};
        // Downstream busy for 5 cycles mid-packet.
        tbl[8]  = '{1'b0, 16'h8010, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h8010, 1'b1, 1'b0, 1'b0};
        for (int i = 9; i < 14; i++)
            tbl[i] = '{1'b0, 16'h0011, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0011, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 16'h0011, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0011, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 16'h2012, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h2012, 1'b1, 1'b0, 1'b0};
        // Headless boundary flit: forwarded, popped, err_hdr for one cycle.
        tbl[16] = '{1'b1, 16'h0000, 1'b0, 16'h0007, 1'b0, 1'b1, 1'b0, 16'h0007, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[18] = '{1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        // Regular 4-flit packet; priority arrives mid-packet, mid-packet HEAD bit is body.
        tbl[19] = '{1'b1, 16'h0000, 1'b0, 16'h8100, 1'b0, 1'b1, 1'b0, 16'h8100, 1'b0, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 16'hA000, 1'b0, 16'h8101, 1'b0, 1'b1, 1'b0, 16'h8101, 1'b0, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 16'hA000, 1'b0, 16'h0102, 1'b0, 1'b1, 1'b0, 16'h0102, 1'b0, 1'b1, 1'b0};
        tbl[22] = '{1'b0, 16'hA000, 1'b0, 16'h2103, 1'b0, 1'b1, 1'b0, 16'h2103, 1'b0, 1'b1, 1'b0};
        // Busy at a boundary: offered but not popped, then taken.
        tbl[23] = '{1'b0, 16'hA000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hA000, 1'b0, 1'b0, 1'b0};
        tbl[24] = '{1'b0, 16'hA000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hA000, 1'b1, 1'b0, 1'b0};

        // Reset: nothing offered or popped even with data waiting.
        rst          = 1'b1;
        pri_empty    = 1'b0;
        pri_data     = 16'h8001;
        reg_empty    = 1'b0;
        reg_data     = 16'h8002;
        output_bussy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset req", 16'(output_req), 16'd0);
        check("reset pri_read", 16'(pri_read), 16'd0);
        check("reset reg_read", 16'(reg_read), 16'd0);
        check("reset err_hdr", 16'(err_hdr), 16'd0);

        for (int i = 0; i < NVEC; i++)
            apply_and_check(tbl[i], $sformatf("vec%0d", i));

        // Both sides hold single-flit packets: four priority grants, then one regular.
        for (int i = 0; i < 10; i++)
            apply_and_check(both_single(i % 5 != 4), $sformatf("starve%0d", i));

        // Raise the counter to 2, lock priority, then reset mid-packet.
        apply_and_check(both_single(1'b1), "pre_rst_p");
        apply_and_check('{1'b0, 16'h8001, 1'b0, 16'hA0FF, 1'b0, 1'b1, 1'b1, 16'h8001, 1'b1, 1'b0, 1'b0},
                        "pre_rst_head");
        @(negedge clk);
        rst      = 1'b1;
        pri_data = 16'h0002;
        #1;
        check("midrst req", 16'(output_req), 16'd0);
        check("midrst pri_read", 16'(pri_read), 16'd0);
        check("midrst reg_read", 16'(reg_read), 16'd0);
        // Back in IDLE with a cleared counter: regular is forced only on the fifth grant.
        for (int i = 0; i < 5; i++)
            apply_and_check(both_single(i != 4), $sformatf("post_rst%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
